rs_issue_select: RTL and testbench
==================================

// Module: rs_issue_select
// PURPOSE
//  Registered allocate/issue selector for a reservation station (RS) of NUM_ENTRY slots.
//  Allocation picks the lowest-index free slot, combinationally.
//  Issue picks among ready, busy entries with fair round-robin priority, or oldest-first when
//  RS_AGE_ORDER_EN is defined. The pick is held in an output register under a valid/ready handshake.
//  Sits between the RS entry array and the ALU/issue port; owns no entry payload.
// PARAMETERS
//  NUM_ENTRY  16                     number of RS slots; power of two, >=2
//  IDX_W      $clog2(NUM_ENTRY)      slot index width
//  CNT_W      $clog2(NUM_ENTRY+1)    free-count width
// PORTS
//  clk_in         in   1          clock
//  rst_in         in   1          asynchronous, active-low reset
//  rdy_in         in   1          global ready; 0 = freeze all state
//  flush_in       in   1          branch-mispredict clear
//  busy_in        in   NUM_ENTRY  slot holds a live instruction
//  prepared_in    in   NUM_ENTRY  slot operands ready (ignored where busy_in=0)
//  alloc_req_in   in   1          decoder wants a slot this cycle
//  alloc_ok_out   out  1          a free slot exists (comb)
//  alloc_idx_out  out  IDX_W      lowest free slot (comb; 0 when none)
//  iss_valid_out  out  1          registered issue request valid
//  iss_idx_out    out  IDX_W      registered slot being issued
//  iss_ready_in   in   1          consumer accepts iss_idx_out this cycle
//  free_cnt_out   out  CNT_W      registered popcount(~busy_in)
// BEHAVIOUR
//  - Reset (rst_in=0, async): iss_valid_out=0, iss_idx_out=0, free_cnt_out=NUM_ENTRY,
//    rr_ptr=0, age matrix=0. Takes effect mid-operation; a pending issue is dropped.
//  - Alloc fire = alloc_req_in & alloc_ok_out & rdy_in & ~flush_in. No state is touched except
//    the age matrix. The RS array sets busy for the slot next cycle.
//  - Candidates cand = busy_in & prepared_in, with iss_idx_out masked out while iss_valid_out=1.
//    This prevents a double issue while the RS clears busy one cycle after acceptance.
//  - Load enable ld = rdy_in & (~iss_valid_out | iss_ready_in).
//    On ld: iss_valid_out<=|cand and iss_idx_out<=pick. If cand=0, iss_valid_out<=0 and
//    iss_idx_out holds.
//  - While iss_valid_out=1 & iss_ready_in=0, iss_idx_out is stable. Issue latency = 1 cycle
//    from prepared to iss_valid_out; back-to-back issue every cycle.
//  - RR pick: first set bit of cand scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_ENTRY.
//    On a valid load, rr_ptr<=pick+1, wrapping at NUM_ENTRY-1 -> 0.
//  - free_cnt_out<=popcount(~busy_in) each rdy_in cycle.
//  - flush_in=1 (rdy_in=1): iss_valid_out<=0, rr_ptr<=0, age<=0, no alloc fire. Overrides ld.
//  - rdy_in=0: every register holds. Comb outputs still track the inputs.
//  - Full (busy_in all 1): alloc_ok_out=0, alloc_idx_out=0. Empty: iss_valid_out falls on next ld.
// CONFIGURATION
//  RS_AGE_ORDER_EN defined:
//   - NUM_ENTRY x NUM_ENTRY age matrix; age[i][j]=1 means i is older than j.
//   - Alloc fire at slot k: row k<=0, and column k<=1 for all i!=k.
//   - pick = the c in cand with age[c][j]=1 for every other j in cand (oldest ready).
//   - rr_ptr is unused.
//  RS_AGE_ORDER_EN undefined: round-robin as above; no age storage is synthesised.
// STRUCTURE
//  - Const.v holds `RS_SIZE/`RS_BIT as the defaults for NUM_ENTRY/IDX_W, plus the
//    RS_AGE_ORDER_EN switch.
//  - Sub-module rs_rr_pick: combinational rotate-priority encoder
//    (req, base -> found, idx), parametrised by NUM_ENTRY.
//  - Lowest-free search, age matrix and issue register stay in rs_issue_select.
// TESTING
//  1 Reset, busy_in=0 -> alloc_ok_out=1, alloc_idx_out=0, free_cnt_out=16 one cycle later,
//    iss_valid_out=0.
//  2 busy=prepared=0x0012, iss_ready_in=1, RR -> iss_idx_out=1 then 4; never 1 twice while
//    busy still set.
//  3 Hold: iss_ready_in=0 for 5 cycles while prepared changes -> iss_idx_out constant;
//    on accept, next pick loads.
//  4 busy_in=0xFFFF -> alloc_ok_out=0, alloc_idx_out=0, free_cnt_out=0.
//    Slot 7 frees -> alloc_idx_out=7.
//  5 Issue pending, flush_in=1 -> next cycle iss_valid_out=0, rr_ptr=0.
//    rdy_in=0 stretch -> all outputs frozen.
//  6 RS_AGE_ORDER_EN: alloc 5, 2, 9; all prepared -> issue order 5, 2, 9.
//    Without the macro, the same stimulus issues 2, 5, 9.

Source files
------------

// File: rtl/rs_issue_select_pkg.sv
// Shared defaults for the reservation-station issue selector.
// The oldest-first issue policy is selected by defining RS_AGE_ORDER_EN at build time.
package rs_issue_select_pkg;

    localparam int RS_SIZE = 16;
    localparam int RS_BIT  = $clog2(RS_SIZE);

endpackage

// File: rtl/rs_rr_pick.sv
// Rotate-priority encoder: first set bit of req scanning base, base+1, ... modulo NUM_ENTRY.
module rs_rr_pick #(
    parameter int NUM_ENTRY = 16,
    parameter int IDX_W     = $clog2(NUM_ENTRY)
) (
    input  logic [NUM_ENTRY-1:0] req,
    input  logic [IDX_W-1:0]     base,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);

    logic [IDX_W-1:0] pos;

    // Scanning offsets from high to low lets the smallest offset win; NUM_ENTRY is a power of two so the index wraps on its own.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = NUM_ENTRY - 1; k >= 0; k--) begin
            pos = base + IDX_W'(k);
            if (req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/rs_issue_select.sv
// Allocate/issue selector for a reservation station: lowest-free allocation, registered issue pick.
// Round-robin issue by default; oldest-first via an age matrix when RS_AGE_ORDER_EN is defined.
module rs_issue_select
    import rs_issue_select_pkg::*;
#(
    parameter int NUM_ENTRY = RS_SIZE,
    parameter int IDX_W     = $clog2(NUM_ENTRY),
    parameter int CNT_W     = $clog2(NUM_ENTRY + 1)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic [NUM_ENTRY-1:0] busy_in,
    input  logic [NUM_ENTRY-1:0] prepared_in,
    input  logic                 alloc_req_in,
    output logic                 alloc_ok_out,
    output logic [IDX_W-1:0]     alloc_idx_out,
    output logic                 iss_valid_out,
    output logic [IDX_W-1:0]     iss_idx_out,
    input  logic                 iss_ready_in,
    output logic [CNT_W-1:0]     free_cnt_out
);

    localparam logic [NUM_ENTRY-1:0] ONE = {{(NUM_ENTRY-1){1'b0}}, 1'b1};

    logic                 alloc_fire;
    logic [NUM_ENTRY-1:0] issued_mask;
    logic [NUM_ENTRY-1:0] cand;
    logic                 ld;
    logic                 found;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W-1:0]     scan_base;
    logic [IDX_W-1:0]     scan_idx;
    logic [CNT_W-1:0]     free_cnt_next;

    always_comb begin
        alloc_ok_out  = 1'b0;
        alloc_idx_out = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (!busy_in[i]) begin
                alloc_ok_out  = 1'b1;
                alloc_idx_out = IDX_W'(i);
            end
        end
    end

    always_comb begin
        free_cnt_next = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            free_cnt_next = free_cnt_next + {{(CNT_W-1){1'b0}}, ~busy_in[i]};
        end
    end

    assign alloc_fire = alloc_req_in & alloc_ok_out & rdy_in & ~flush_in;

    // The slot held in the issue register stays busy one more cycle after acceptance, so keep it out of the pick.
    assign issued_mask = iss_valid_out ? (ONE << iss_idx_out) : '0;
    assign cand        = busy_in & prepared_in & ~issued_mask;
    assign ld          = rdy_in & (~iss_valid_out | iss_ready_in);

    rs_rr_pick #(
        .NUM_ENTRY(NUM_ENTRY),
        .IDX_W    (IDX_W)
    ) u_rr_pick (
        .req  (cand),
        .base (scan_base),
        .found(found),
        .idx  (scan_idx)
    );

`ifdef RS_AGE_ORDER_EN
    logic [NUM_ENTRY-1:0] age [NUM_ENTRY];
    logic                 age_found;
    logic [IDX_W-1:0]     age_pick;

    // Slot k becomes the youngest on allocation: it is older than nobody, everyone else is older than it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_ENTRY; i++) age[i] <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                for (int i = 0; i < NUM_ENTRY; i++) age[i] <= '0;
            end else if (alloc_fire) begin
                for (int i = 0; i < NUM_ENTRY; i++) begin
                    for (int j = 0; j < NUM_ENTRY; j++) begin
                        if (IDX_W'(i) == alloc_idx_out) begin
                            age[i][j] <= 1'b0;
                        end else if (IDX_W'(j) == alloc_idx_out) begin
                            age[i][j] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        age_found = 1'b0;
        age_pick  = '0;
        for (int c = NUM_ENTRY - 1; c >= 0; c--) begin
            if (cand[c] && (&(age[c] | ~cand | (ONE << c)))) begin
                age_found = 1'b1;
                age_pick  = IDX_W'(c);
            end
        end
    end

    // Slots that were never allocated through this block carry no age; fall back to lowest index.
    assign scan_base = '0;
    assign pick      = age_found ? age_pick : scan_idx;
`else
    logic [IDX_W-1:0] rr_ptr;
    logic             unused_alloc_fire;

    assign unused_alloc_fire = alloc_fire;
    assign scan_base         = rr_ptr;
    assign pick              = scan_idx;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                rr_ptr <= '0;
            end else if (ld && found) begin
                rr_ptr <= pick + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            iss_valid_out <= 1'b0;
            iss_idx_out   <= '0;
            free_cnt_out  <= CNT_W'(NUM_ENTRY);
        end else if (rdy_in) begin
            free_cnt_out <= free_cnt_next;
            if (flush_in) begin
                iss_valid_out <= 1'b0;
            end else if (ld) begin
                iss_valid_out <= found;
                if (found) iss_idx_out <= pick;
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed self-checking bench for rs_issue_select; expected issue order follows RS_AGE_ORDER_EN.
module tb_rs_issue_select;

    localparam int N     = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             rdy = 1'b1;
    logic             flush = 1'b0;
    logic             alloc_req = 1'b0;
    logic             iss_ready = 1'b0;
    logic [N-1:0]     busy = '0;
    logic [N-1:0]     prepared = '0;
    logic             alloc_ok;
    logic [IDX_W-1:0] alloc_idx;
    logic             iss_valid;
    logic [IDX_W-1:0] iss_idx;
    logic [CNT_W-1:0] free_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rs_issue_select #(.NUM_ENTRY(N)) dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .rdy_in       (rdy),
        .flush_in     (flush),
        .busy_in      (busy),
        .prepared_in  (prepared),
        .alloc_req_in (alloc_req),
        .alloc_ok_out (alloc_ok),
        .alloc_idx_out(alloc_idx),
        .iss_valid_out(iss_valid),
        .iss_idx_out  (iss_idx),
        .iss_ready_in (iss_ready),
        .free_cnt_out (free_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] b, input logic [N-1:0] p, input logic req,
                                 input logic ready, input logic fl, input logic r);
        busy      = b;
        prepared  = p;
        alloc_req = req;
        iss_ready = ready;
        flush     = fl;
        rdy       = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_order [3];
        logic [N-1:0] prep_list [5];
        int exp_free;
`ifdef RS_AGE_ORDER_EN
        exp_order = '{5, 2, 9};
`else
        exp_order = '{2, 5, 9};
`endif
        prep_list = '{16'h0F00, 16'h00F0, 16'hFFFF, 16'h1234, 16'h8001};

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_valid", 32'(iss_valid), 32'd0);
        checkOutput("reset_idx", 32'(iss_idx), 32'd0);
        checkOutput("reset_free", 32'(free_cnt), 32'd16);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        $display("[TB] reset released");

        // Empty station
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("empty_alloc_ok", 32'(alloc_ok), 32'd1);
        checkOutput("empty_alloc_idx", 32'(alloc_idx), 32'd0);
        tick;
        checkOutput("empty_free", 32'(free_cnt), 32'd16);
        checkOutput("empty_valid", 32'(iss_valid), 32'd0);

        // Round robin over slots 1 and 4, busy lags one cycle
        applyStimulus(16'h0012, 16'h0012, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;
        checkOutput("rr_first_valid", 32'(iss_valid), 32'd1);
        checkOutput("rr_first_idx", 32'(iss_idx), 32'd1);
        tick;
        checkOutput("rr_second_idx", 32'(iss_idx), 32'd4);
        applyStimulus(16'h0010, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;
        checkOutput("rr_drain_valid", 32'(iss_valid), 32'd0);
        checkOutput("rr_drain_idx", 32'(iss_idx), 32'd4);
        applyStimulus(16'h0002, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;
        checkOutput("rr_wrap_idx", 32'(iss_idx), 32'd1);
        tick;
        checkOutput("no_double_issue", 32'(iss_valid), 32'd0);

        // Hold under back-pressure
        applyStimulus(16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        checkOutput("hold_load_idx", 32'(iss_idx), 32'd8);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(16'hFFFF, prep_list[k], 1'b0, 1'b0, 1'b0, 1'b1);
            tick;
            checkOutput("hold_valid", 32'(iss_valid), 32'd1);
            checkOutput("hold_idx", 32'(iss_idx), 32'd8);
        end
        applyStimulus(16'h0240, 16'h0240, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;
        checkOutput("accept_next_idx", 32'(iss_idx), 32'd9);
        applyStimulus(16'h0040, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;
        checkOutput("rr_wrap2_idx", 32'(iss_idx), 32'd6);
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;
        checkOutput("idle_valid", 32'(iss_valid), 32'd0);

        // Full station, then slot 7 frees
        applyStimulus(16'hFFFF, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("full_alloc_ok", 32'(alloc_ok), 32'd0);
        checkOutput("full_alloc_idx", 32'(alloc_idx), 32'd0);
        tick;
        checkOutput("full_free", 32'(free_cnt), 32'd0);
        applyStimulus(16'hFF7F, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("slot7_alloc_ok", 32'(alloc_ok), 32'd1);
        checkOutput("slot7_alloc_idx", 32'(alloc_idx), 32'd7);
        tick;
        checkOutput("slot7_free", 32'(free_cnt), 32'd1);

        // Flush a pending issue, then freeze with rdy low
        applyStimulus(16'h0008, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        checkOutput("pend_idx", 32'(iss_idx), 32'd3);
        applyStimulus(16'h0008, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b1);
        tick;
        checkOutput("flush_valid", 32'(iss_valid), 32'd0);
        checkOutput("flush_free", 32'(free_cnt), 32'd15);
        applyStimulus(16'h0024, 16'h0024, 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        checkOutput("flush_ptr_idx", 32'(iss_idx), 32'd2);
        exp_free = 14;
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("frozen_comb_ok", 32'(alloc_ok), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick;
            checkOutput("frozen_valid", 32'(iss_valid), 32'd1);
            checkOutput("frozen_idx", 32'(iss_idx), 32'd2);
            checkOutput("frozen_free", 32'(free_cnt), 32'(exp_free));
        end
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;
        checkOutput("thaw_valid", 32'(iss_valid), 32'd0);
        checkOutput("thaw_free", 32'(free_cnt), 32'd16);

        // Allocate 5, 2, 9 then issue all three
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick;
        applyStimulus(16'hFFDF, '0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("alloc_a_idx", 32'(alloc_idx), 32'd5);
        tick;
        applyStimulus(16'hFFFB, '0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("alloc_b_idx", 32'(alloc_idx), 32'd2);
        tick;
        applyStimulus(16'hFDFF, '0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("alloc_c_idx", 32'(alloc_idx), 32'd9);
        tick;
        applyStimulus(16'hFFFF, 16'h0224, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick;
            checkOutput("order_valid", 32'(iss_valid), 32'd1);
            checkOutput("order_idx", 32'(iss_idx), 32'(exp_order[k]));
            prepared[exp_order[k]] = 1'b0;
            busy[exp_order[k]]     = 1'b0;
        end
        tick;
        checkOutput("order_drain", 32'(iss_valid), 32'd0);

        // Asynchronous reset drops a pending issue
        applyStimulus(16'h0800, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        checkOutput("pre_reset_idx", 32'(iss_idx), 32'd11);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(iss_valid), 32'd0);
        checkOutput("async_reset_idx", 32'(iss_idx), 32'd0);
        checkOutput("async_reset_free", 32'(free_cnt), 32'd16);
        @(negedge clk) rst_n = 1'b1;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
